burst_main_memory: RTL and testbench

BURST_MAIN_MEMORY -- requirements
Module: burst_main_memory

---
 rtl/burst_main_memory.sv | 112 +++++++++++
 tb/tb_burst_main_memory.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_main_memory.sv
// Word-addressed memory with byte-enable writes and critical-word-first wrapping burst reads.
// Fixed request-to-first-beat latency, and full rd_valid/rd_ready backpressure on read beats.
module burst_main_memory #(
   parameter int WORD_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH_LOG2   = 12,
   parameter int BURST_LEN    = 4,
   parameter int READ_LATENCY = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   input  logic [ADDR_WIDTH-3:0]   wr_addr,
   input  logic [WORD_WIDTH-1:0]   wr_data,
   input  logic [WORD_WIDTH/8-1:0] wr_be,
   input  logic                    rd_req_valid,
   output logic                    rd_req_ready,
   input  logic [ADDR_WIDTH-3:0]   rd_addr,
   output logic [WORD_WIDTH-1:0]   rd_data,
   output logic                    rd_valid,
   output logic                    rd_last,
   input  logic                    rd_ready
);

   localparam int DEPTH  = 2 ** DEPTH_LOG2;
   localparam int NBYTES = WORD_WIDTH / 8;
   localparam int WA     = ADDR_WIDTH - 2;
   localparam int BEAT_W = $clog2(BURST_LEN + 1);
   localparam int LAT_W  = $clog2(READ_LATENCY + 1);
   localparam logic [WA-1:0] LINE_MASK = WA'(BURST_LEN - 1);

   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t              state;
   logic [WA-1:0]       addr_q;
   logic [LAT_W-1:0]    lat_cnt;
   logic [BEAT_W-1:0]   beat_cnt;
   logic [WA-1:0]       beat_addr;
   logic                rd_fire;
   logic                unused_addr_bits;

   // Contents start at zero; rst never touches the array.
   logic [WORD_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   assign wr_ready     = (state == IDLE);
   assign rd_req_ready = (state == IDLE) && !wr_valid;
   assign rd_fire      = rd_req_valid && rd_req_ready;

   // Wrap within the aligned line, starting at the critical word.
   assign beat_addr = (addr_q & ~LINE_MASK) | ((addr_q + WA'(beat_cnt)) & LINE_MASK);

   assign unused_addr_bits = ^{wr_addr, beat_addr};

   always_ff @(posedge clk) begin
      if (wr_valid && wr_ready) begin
         for (int k = 0; k < NBYTES; k++) begin
            if (wr_be[k]) begin
               mem[wr_addr[DEPTH_LOG2-1:0]][8*k +: 8] <= wr_data[8*k +: 8];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         addr_q   <= '0;
         lat_cnt  <= '0;
         beat_cnt <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (rd_fire) begin
                  addr_q   <= rd_addr;
                  lat_cnt  <= '0;
                  beat_cnt <= '0;
                  state    <= (READ_LATENCY > 1) ? WAIT : BURST;
               end
            end
            WAIT: begin
               // BURST issues the first beat one edge after entry, hence the -2.
               if (int'(lat_cnt) == READ_LATENCY - 2) begin
                  state <= BURST;
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            BURST: begin
               if (!rd_valid || rd_ready) begin
                  if (rd_valid && rd_last) begin
                     rd_valid <= 1'b0;
                     rd_last  <= 1'b0;
                     beat_cnt <= '0;
                     state    <= IDLE;
                  end else begin
                     rd_data  <= mem[beat_addr[DEPTH_LOG2-1:0]];
                     rd_valid <= 1'b1;
                     rd_last  <= (beat_cnt == BEAT_W'(BURST_LEN - 1));
                     beat_cnt <= beat_cnt + BEAT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_burst_main_memory.sv
// Scoreboard bench for burst_main_memory: stimulus pushes expected beats, a monitor pops and compares.
module tb_burst_main_memory;

   localparam int WW    = 32;
   localparam int AW    = 32;
   localparam int DL    = 12;
   localparam int BL    = 4;
   localparam int RL    = 3;
   localparam int DEPTH = 1 << DL;

   logic          clk = 1'b0;
   logic          rst;
   logic          wr_valid;
   logic          wr_ready;
   logic [AW-3:0] wr_addr;
   logic [WW-1:0] wr_data;
   logic [3:0]    wr_be;
   logic          rd_req_valid;
   logic          rd_req_ready;
   logic [AW-3:0] rd_addr;
   logic [WW-1:0] rd_data;
   logic          rd_valid;
   logic          rd_last;
   logic          rd_ready = 1'b1;

   burst_main_memory #(
      .WORD_WIDTH  (WW),
      .ADDR_WIDTH  (AW),
      .DEPTH_LOG2  (DL),
      .BURST_LEN   (BL),
      .READ_LATENCY(RL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .rd_req_valid(rd_req_valid),
      .rd_req_ready(rd_req_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .rd_last     (rd_last),
      .rd_ready    (rd_ready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        last;
   } beat_t;

   beat_t       exp_q[$];
   time         acc_q[$];
   logic [31:0] model [DEPTH];
   int          tests = 0;
   int          failures = 0;
   int          mode = 1;            // 0 random ready, 1 ready high, 2 stall beat 1 for two cycles
   int          beat_in_burst = 0;
   int          hold_cnt = 0;
   logic        prev_valid = 1'b0;
   logic        prev_stall = 1'b0;
   logic        prev_last = 1'b0;
   logic [31:0] prev_data = '0;
   time         t_acc;
   beat_t       e_mon;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      failures++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: plain word array, byte lanes, index = address mod depth.
   task automatic model_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
      int unsigned idx = int'(a) % DEPTH;
      for (int k = 0; k < 4; k++) begin
         if (be[k]) model[idx][8*k +: 8] = d[8*k +: 8];
      end
   endtask

   task automatic push_burst(input logic [29:0] a);
      int unsigned au = int'(a);
      int unsigned w;
      beat_t       e;
      for (int i = 0; i < BL; i++) begin
         w      = (au - (au % BL)) + ((au + i) % BL);
         e.data = model[w % DEPTH];
         e.last = (i == BL - 1);
         exp_q.push_back(e);
      end
      acc_q.push_back($time);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || rd_valid) && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 300) begin
         fail_now("burst_completion_timeout");
         exp_q.delete();
         acc_q.delete();
      end
   endtask

   task automatic do_write(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
      int n = 0;
      wr_valid = 1'b1;
      wr_addr  = a;
      wr_data  = d;
      wr_be    = be;
      do begin
         @(negedge clk);
         n++;
      end while (!wr_ready && n < 50);
      if (!wr_ready) fail_now("write_accept_timeout");
      @(posedge clk);
      if (n < 50) model_write(a, d, be);
      #1 wr_valid = 1'b0;
   endtask

   task automatic do_read(input logic [29:0] a, input bit wait_done);
      int n = 0;
      rd_req_valid = 1'b1;
      rd_addr      = a;
      do begin
         @(negedge clk);
         n++;
      end while (!rd_req_ready && n < 50);
      if (!rd_req_ready) fail_now("read_accept_timeout");
      @(posedge clk);
      if (n < 50) push_burst(a);
      #1 rd_req_valid = 1'b0;
      if (wait_done) wait_idle();
   endtask

   always @(posedge clk) begin
      #1;
      if (mode == 0) rd_ready = ($urandom_range(0, 3) != 0);
      else if (mode == 2) rd_ready = !(rd_valid && beat_in_burst == 1 && hold_cnt < 2);
      else rd_ready = 1'b1;
   end

   // Monitor: samples on the falling edge, between driver updates and DUT edges.
   always @(negedge clk) begin
      if (rst) begin
         prev_valid    = 1'b0;
         prev_stall    = 1'b0;
         hold_cnt      = 0;
         beat_in_burst = 0;
         exp_q.delete();
         acc_q.delete();
      end else begin
         if (prev_stall) begin
            check("stall_hold_valid", rd_valid, 1);
            check("stall_hold_data", rd_data, prev_data);
            check("stall_hold_last", rd_last, prev_last);
         end
         if (rd_valid && !prev_valid) begin
            if (acc_q.size() == 0) fail_now("unexpected_burst_start");
            else begin
               t_acc = acc_q.pop_front();
               check("first_beat_latency", ($time - t_acc - 5) / 10, RL);
            end
         end
         if (rd_valid) hold_cnt++;
         if (rd_valid && rd_ready) begin
            if (exp_q.size() == 0) fail_now("unexpected_beat");
            else begin
               e_mon = exp_q.pop_front();
               check("beat_data", rd_data, e_mon.data);
               check("beat_last", rd_last, e_mon.last);
               if (mode == 2 && beat_in_burst == 1) check("stall_beat1_cycles", hold_cnt, 3);
            end
            hold_cnt      = 0;
            beat_in_burst = rd_last ? 0 : beat_in_burst + 1;
         end
         prev_stall = rd_valid && !rd_ready;
         prev_data  = rd_data;
         prev_last  = rd_last;
         prev_valid = rd_valid;
      end
   end

   initial begin
      int          n;
      logic [29:0] a;
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
      rst          = 1'b1;
      wr_valid     = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      wr_be        = '0;
      rd_req_valid = 1'b0;
      rd_addr      = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_rd_valid", rd_valid, 0);
      check("reset_rd_last", rd_last, 0);
      check("reset_rd_data", rd_data, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_wr_ready", wr_ready, 1);
      check("post_reset_rd_req_ready", rd_req_ready, 1);
      @(posedge clk);
      #1;

      // Byte-enable merge
      do_write(30'h10, 32'hAABBCCDD, 4'hF);
      do_write(30'h10, 32'h11223344, 4'h5);
      do_read(30'h10, 1'b1);

      // Wrap burst from the critical word
      for (int i = 0; i < 4; i++) do_write(30'h20 + 30'(i), 32'hA0 + 32'(i), 4'hF);
      do_read(30'h22, 1'b1);

      // Backpressure on beat 1
      mode = 2;
      do_read(30'h22, 1'b1);
      mode = 1;

      // Simultaneous write and read request: write wins, read follows
      wr_valid     = 1'b1;
      wr_addr      = 30'h30;
      wr_data      = 32'h5A5A0001;
      wr_be        = 4'hF;
      rd_req_valid = 1'b1;
      rd_addr      = 30'h30;
      @(negedge clk);
      check("simul_wr_ready", wr_ready, 1);
      check("simul_rd_req_ready", rd_req_ready, 0);
      @(posedge clk);
      model_write(30'h30, 32'h5A5A0001, 4'hF);
      #1 wr_valid = 1'b0;
      @(negedge clk);
      check("simul_rd_req_ready_next", rd_req_ready, 1);
      @(posedge clk);
      push_burst(30'h30);
      #1 rd_req_valid = 1'b0;
      wait_idle();

      // Aliasing above the depth
      do_write(30'h1005, 32'h55, 4'hF);
      do_read(30'h005, 1'b1);

      // Reset during beat 2
      do_read(30'h20, 1'b0);
      n = 0;
      while (beat_in_burst != 2 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 50) fail_now("reach_beat2_timeout");
      check("pre_reset_rd_valid", rd_valid, 1);
      rst = 1'b1;
      #1;
      check("async_rst_rd_valid", rd_valid, 0);
      check("async_rst_rd_last", rd_last, 0);
      check("async_rst_rd_data", rd_data, 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_release_wr_ready", wr_ready, 1);
      check("rst_release_rd_req_ready", rd_req_ready, 1);
      check("rst_release_no_beat", rd_valid, 0);
      repeat (8) @(posedge clk);
      #1;
      do_read(30'h20, 1'b1);

      // Randomized mix of writes and reads
      for (int it = 0; it < 120; it++) begin
         mode = ($urandom_range(0, 2) != 0) ? 0 : 1;
         a    = 30'($urandom_range(0, 63));
         if ($urandom_range(0, 3) == 0) a = a | (30'($urandom_range(1, 15)) << 12);
         if ($urandom_range(0, 1) == 1) do_write(a, $urandom, 4'($urandom_range(0, 15)));
         else do_read(a, 1'b1);
      end
      mode = 1;
      repeat (4) @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
